// File: rtl/avalon_st_pkg.sv
// Shared definitions for the Avalon-ST packet arbiter.
//   state_e     : arbiter FSM encoding (IDLE = arbitrate, LOCK = stream one packet)
//   AVST_DATA_W : default beat data width
//   AVST_CH_W   : default channel width
package avalon_st_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int AVST_DATA_W = 8;
  localparam int AVST_CH_W   = 2;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority requester select (purely combinational).
//   req        : request vector, one bit per source
//   last_grant : source granted most recently; it gets lowest priority
//   any_req    : at least one request present
//   next_grant : first requester found scanning upward from last_grant+1, wrapping
module rr_select #(
  parameter int NUM_SRC = 3,
  parameter int CH_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [CH_W-1:0]    last_grant,
  output logic               any_req,
  output logic [CH_W-1:0]    next_grant
);

  always_comb begin
    int idx;
    idx        = 0;
    any_req    = |req;
    next_grant = '0;
    // Walk from the farthest position down to the nearest so the nearest
    // requester after last_grant is the one left standing.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (req[idx]) next_grant = CH_W'(idx);
    end
  end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST sink.
//   clk, reset              : clock, synchronous active-high reset
//   src_valid/data/eop      : per-source beat inputs (source i at data[i*DATA_W +: DATA_W])
//   src_ready               : per-source ready, combinational
//   out_valid/data/eop      : registered beat to the sink
//   out_channel             : source index of the current out beat
//   out_ready               : sink ready
//   busy                    : a grant is locked
// A grant is locked from the arbitration cycle until the granted source's
// eop beat is accepted; each packet costs one IDLE (arbitration) cycle.
module avalon_st_packet_arbiter
  import avalon_st_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = AVST_DATA_W,
  parameter int CH_W    = AVST_CH_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_eop,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_eop,
  output logic [CH_W-1:0]           out_channel,
  input  logic                      out_ready,
  output logic                      busy
);

  if (NUM_SRC < 2 || (1 << CH_W) < NUM_SRC) begin : g_bad_param
    $error("avalon_st_packet_arbiter: need NUM_SRC >= 2 and 2**CH_W >= NUM_SRC");
  end

  state_e                           state, state_nxt;
  logic   [CH_W-1:0]                grant, last_grant, sel;
  logic                             any_req;
  logic   [NUM_SRC-1:0][DATA_W-1:0] lane_data;
  logic                             g_valid, g_eop;
  logic   [DATA_W-1:0]              g_data;
  logic                             load, acc;

  assign lane_data = src_data;

  rr_select #(.NUM_SRC(NUM_SRC), .CH_W(CH_W)) u_rr (
    .req        (src_valid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .next_grant (sel)
  );

  // Granted-lane mux; compare against each index rather than indexing with
  // grant so the index width never has to match NUM_SRC.
  always_comb begin
    g_valid = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == CH_W'(i)) begin
        g_valid = src_valid[i];
        g_eop   = src_eop[i];
        g_data  = lane_data[i];
      end
    end
  end

  // Output register can take a beat when empty or being drained this cycle.
  assign load = !out_valid || out_ready;
  assign acc  = (state == ST_LOCK) && load && g_valid;
  assign busy = (state == ST_LOCK);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign src_ready[i] = (state == ST_LOCK) && load && (grant == CH_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req)       state_nxt = ST_LOCK;
      ST_LOCK: if (acc && g_eop)  state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_eop     <= 1'b0;
      out_channel <= '0;
      grant       <= '0;
      last_grant  <= CH_W'(NUM_SRC - 1);
    end else begin
      if (state == ST_IDLE && any_req) grant <= sel;
      if (acc) begin
        out_valid   <= 1'b1;
        out_data    <= g_data;
        out_eop     <= g_eop;
        out_channel <= grant;
        if (g_eop) last_grant <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
module tb_avalon_st_packet_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      src_valid, src_eop, src_ready;
  logic [N*DW-1:0]   src_data;
  logic              out_valid, out_eop, out_ready, busy;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_channel;

  avalon_st_packet_arbiter #(.NUM_SRC(N), .DATA_W(DW), .CH_W(CW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_eop(src_eop), .src_ready(src_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop), .out_channel(out_channel),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // per-source pending beats {eop,data}, and expected sink stream per channel
  logic [8:0] srcq [N][$];
  logic [8:0] sbq  [N][$];
  int stall [N];
  int acc_cnt [N];
  int vpct, rpct;

  // reference model: packet owner (-1 = arbitrating), last owner, output register
  int owner, last;
  bit ev, ee;
  logic [7:0] ed;
  int ec;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_pkt(input int s, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      logic [8:0] b;
      b = {(k == n - 1), 8'(base + k)};
      srcq[s].push_back(b);
      sbq[s].push_back(b);
    end
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int i = 0; i < N; i++) p += srcq[i].size() + sbq[i].size();
    if (owner >= 0) p++;
    if (ev) p++;
    return p;
  endfunction

  // One cycle: entered just after a falling edge, leaves just after the next one.
  task automatic step(input bit rst);
    logic [N-1:0] rdy_e;
    bit acc;
    int own_n, last_n, ec_n;
    bit ev_n, ee_n;
    logic [7:0] ed_n;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      if (stall[i] > 0) begin
        stall[i]--;
        src_valid[i] = 1'b0;
        src_data[i*DW +: DW] = 8'($urandom);
        src_eop[i] = 1'($urandom);
      end else if (srcq[i].size() > 0 && ($urandom % 100) < vpct) begin
        src_valid[i] = 1'b1;
        src_data[i*DW +: DW] = srcq[i][0][7:0];
        src_eop[i] = srcq[i][0][8];
      end else begin
        src_valid[i] = 1'b0;
        src_data[i*DW +: DW] = 8'($urandom);
        src_eop[i] = 1'($urandom);
      end
    end
    out_ready = (($urandom % 100) < rpct);
    #1;
    rdy_e = '0;
    if (owner >= 0 && (!ev || out_ready)) rdy_e[owner] = 1'b1;
    chk("src_ready", src_ready, rdy_e);
    chk("busy", busy, owner >= 0);
    if (!rst && out_valid && out_ready) begin
      if (int'(out_channel) < N) begin
        chk("sink_expected_beat", sbq[out_channel].size() != 0, 1);
        if (sbq[out_channel].size() != 0)
          chk("sink_beat", {out_eop, out_data}, sbq[out_channel].pop_front());
      end else begin
        chk("sink_channel_range", out_channel, 0);
      end
    end
    // model next state
    acc = (owner >= 0) && rdy_e[owner] && src_valid[owner];
    own_n = owner; last_n = last;
    ev_n = ev; ed_n = ed; ee_n = ee; ec_n = ec;
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (own_n < 0 && src_valid[j]) own_n = j;
      end
    end
    if (acc) begin
      ev_n = 1'b1;
      ed_n = src_data[owner*DW +: DW];
      ee_n = src_eop[owner];
      ec_n = owner;
      if (src_eop[owner]) begin
        own_n = -1;
        last_n = owner;
      end
    end else if (out_ready) begin
      ev_n = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (src_valid[i] && src_ready[i]) begin
        if (srcq[i].size() > 0) void'(srcq[i].pop_front());
        acc_cnt[i]++;
      end
    @(posedge clk);
    if (rst) begin
      owner = -1; last = N - 1;
      ev = 1'b0; ed = 8'h00; ee = 1'b0; ec = 0;
      for (int i = 0; i < N; i++) begin
        srcq[i].delete();
        sbq[i].delete();
        stall[i] = 0;
      end
    end else begin
      owner = own_n; last = last_n;
      ev = ev_n; ed = ed_n; ee = ee_n; ec = ec_n;
    end
    @(negedge clk);
    chk("out_valid", out_valid, ev);
    if (ev || rst) begin
      chk("out_data", out_data, ed);
      chk("out_eop", out_eop, ee);
      chk("out_channel", out_channel, ec);
    end
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while (pending() != 0 && c < bound) begin
      step(1'b0);
      c++;
    end
    chk("drain_pending", pending(), 0);
  endtask

  initial begin
    reset = 1'b1; src_valid = '0; src_data = '0; src_eop = '0; out_ready = 1'b0;
    vpct = 100; rpct = 100;
    owner = -1; last = N - 1; ev = 1'b0; ed = 8'h00; ee = 1'b0; ec = 0;
    for (int i = 0; i < N; i++) begin stall[i] = 0; acc_cnt[i] = 0; end
    @(negedge clk);
    step(1'b1);
    step(1'b1);

    // single 3-beat packet from source 0
    push_pkt(0, 3, 4);
    drain(40);

    // three simultaneous 2-beat packets, fresh arbitration
    step(1'b1);
    push_pkt(0, 2, 8'h10);
    push_pkt(1, 2, 8'h20);
    push_pkt(2, 2, 8'h30);
    drain(60);

    // backpressure while 0x20 sits in the output register
    push_pkt(1, 2, 8'h20);
    for (int c = 0; c < 20 && !(out_valid && out_data == 8'h20); c++) step(1'b0);
    chk("bp_reach", out_data, 8'h20);
    rpct = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      chk("bp_hold", out_data, 8'h20);
    end
    rpct = 100;
    drain(40);

    // fairness: source 2 streams single beats, source 0 also requests
    for (int k = 0; k < 8; k++) push_pkt(2, 1, 8'h40 + k);
    for (int k = 0; k < 3; k++) push_pkt(0, 1, 8'h50 + k);
    drain(100);

    // granted source 1 stalls mid-packet while source 0 waits
    push_pkt(1, 4, 8'h60);
    for (int c = 0; c < 10 && !busy; c++) step(1'b0);
    push_pkt(0, 2, 8'h70);
    begin
      int base;
      base = acc_cnt[1];
      for (int c = 0; c < 20 && acc_cnt[1] < base + 2; c++) step(1'b0);
      chk("stall_reach", acc_cnt[1] - base, 2);
    end
    stall[1] = 3;
    drain(60);

    // reset in the middle of a 4-beat packet, then restart from source 0
    step(1'b1);
    begin
      int base;
      base = acc_cnt[0];
      push_pkt(0, 4, 8'h80);
      for (int c = 0; c < 20 && acc_cnt[0] < base + 2; c++) step(1'b0);
      chk("reset_reach", acc_cnt[0] - base, 2);
    end
    step(1'b1);
    push_pkt(2, 1, 8'h92);
    push_pkt(0, 1, 8'h90);
    drain(40);

    // randomized traffic with random gaps and backpressure
    vpct = 70; rpct = 60;
    for (int it = 0; it < 600; it++) begin
      if ($urandom % 4 == 0) begin
        int s;
        s = $urandom % N;
        if (srcq[s].size() < 12) push_pkt(s, $urandom_range(1, 5), $urandom % 256);
      end
      step(1'b0);
    end
    vpct = 100; rpct = 100;
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
